// File: rtl/digit_mult_accum.sv
// rtl/digit_mult_accum.sv - 4x4 unsigned multiplier built from 2-bit digit partial products
//
// Multiplies two 4-bit operands, each presented as two 2-bit digits, by
// accumulating the four digit products over four CALC cycles.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    begin a multiplication (sampled only in IDLE)
//   a_hi     operand A bits [3:2]
//   a_lo     operand A bits [1:0]
//   b_hi     operand B bits [3:2]
//   b_lo     operand B bits [1:0]
//   busy     high in CALC and DONE (decoded from state)
//   done     one-cycle completion pulse (high only in DONE)
//   product  registered 8-bit result, held until the next completion
module digit_mult_accum (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] a_hi,
  input  logic [1:0] a_lo,
  input  logic [1:0] b_hi,
  input  logic [1:0] b_lo,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] step;
  logic [7:0] acc;

  // Operand digits captured on the start edge so later input changes
  // cannot disturb the multiplication in progress.
  logic [1:0] cap_a_hi;
  logic [1:0] cap_a_lo;
  logic [1:0] cap_b_hi;
  logic [1:0] cap_b_lo;

  logic [1:0] a_dig;
  logic [1:0] b_dig;
  logic [3:0] pp;
  logic [2:0] shamt;
  logic [7:0] pp_shifted;
  logic [7:0] sum;

  // step[1] selects the A digit, step[0] the B digit, giving the order
  // lo*lo, lo*hi, hi*lo, hi*hi. The shift is 2*(i+j): 0, 2, 2, 4.
  always_comb begin
    a_dig      = step[1] ? cap_a_hi : cap_a_lo;
    b_dig      = step[0] ? cap_b_hi : cap_b_lo;
    pp         = {2'b00, a_dig} * {2'b00, b_dig};
    shamt      = {step[1] & step[0], step[1] ^ step[0], 1'b0};
    pp_shifted = {4'b0000, pp} << shamt;
    sum        = acc + pp_shifted;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      step     <= 2'd0;
      acc      <= 8'd0;
      product  <= 8'd0;
      done     <= 1'b0;
      cap_a_hi <= 2'd0;
      cap_a_lo <= 2'd0;
      cap_b_hi <= 2'd0;
      cap_b_lo <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cap_a_hi <= a_hi;
            cap_a_lo <= a_lo;
            cap_b_hi <= b_hi;
            cap_b_lo <= b_lo;
            acc      <= 8'd0;
            step     <= 2'd0;
            state    <= CALC;
          end
        end
        CALC: begin
          acc  <= sum;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            // Final partial product goes straight into the result register.
            product <= sum;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_mult_accum.sv
// tb/tb_digit_mult_accum.sv - self-checking bench for digit_mult_accum
module tb_digit_mult_accum;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] a_hi;
  logic [1:0] a_lo;
  logic [1:0] b_hi;
  logic [1:0] b_lo;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks;
  int failures;

  digit_mult_accum dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_hi    (a_hi),
    .a_lo    (a_lo),
    .b_hi    (b_hi),
    .b_lo    (b_lo),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ops(input logic [3:0] a, input logic [3:0] b);
    a_hi = a[3:2];
    a_lo = a[1:0];
    b_hi = b[3:2];
    b_lo = b[1:0];
  endtask

  // Stimulus only: one start pulse, then watch until done (bounded).
  // lat = edges from capture to done; bcyc = cycles busy was seen high.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        output int lat, output int bcyc, output logic [7:0] prod);
    @(negedge clk);
    set_ops(a, b);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat  = 0;
    bcyc = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (busy) bcyc++;
    end
    prod = product;
    @(posedge clk);
    @(negedge clk);
    if (busy) bcyc++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    set_ops(4'd0, 4'd0);
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, product} !== 10'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b product=%h exp all 0", busy, done, product);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    int lat, bcyc;
    logic [7:0] prod;
    run_op(4'd10, 4'd10, lat, bcyc, prod);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL basic_latency got %0d exp 4", lat);
    end
    checks++;
    if (prod !== 8'h64) begin
      failures++;
      $display("FAIL basic_product got %h exp 64", prod);
    end
    checks++;
    if (bcyc !== 5) begin
      failures++;
      $display("FAIL basic_busy_cycles got %0d exp 5", bcyc);
    end
  endtask

  task automatic test_corners;
    int lat, bcyc;
    logic [7:0] prod;
    run_op(4'd15, 4'd15, lat, bcyc, prod);
    checks++;
    if (prod !== 8'hE1) begin
      failures++;
      $display("FAIL max_product got %h exp e1", prod);
    end
    run_op(4'd0, 4'd13, lat, bcyc, prod);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL zero_done got latency %0d exp 4", lat);
    end
    checks++;
    if (prod !== 8'h00) begin
      failures++;
      $display("FAIL zero_product got %h exp 00", prod);
    end
  endtask

  task automatic test_ignore_inputs;
    int ndone;
    logic [7:0] prev;
    bit held;
    prev = product;
    held = 1'b1;
    ndone = 0;
    @(negedge clk);
    set_ops(4'd6, 4'd9);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    set_ops(4'd15, 4'd15);
    for (int k = 1; k <= 12; k++) begin
      start = (k == 1 || k == 2);
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
      if (k < 4 && product !== prev) held = 1'b0;
      if (k == 4) begin
        checks++;
        if (product !== 8'h36) begin
          failures++;
          $display("FAIL ignore_product got %h exp 36", product);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1) begin
      failures++;
      $display("FAIL ignore_done_count got %0d exp 1", ndone);
    end
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL ignore_hold_calc got changed exp held %h", prev);
    end
  endtask

  task automatic test_abort;
    int ndone, lat, bcyc;
    logic [7:0] prod;
    @(negedge clk);
    set_ops(4'd7, 4'd7);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, product} !== 10'd0) begin
      failures++;
      $display("FAIL abort_async got busy=%b done=%b product=%h exp all 0", busy, done, product);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0 || product !== 8'h00) begin
      failures++;
      $display("FAIL abort_no_done got dones=%0d product=%h exp 0 00", ndone, product);
    end
    run_op(4'd3, 4'd5, lat, bcyc, prod);
    checks++;
    if (prod !== 8'h0F || lat !== 4) begin
      failures++;
      $display("FAIL abort_rerun got product=%h lat=%0d exp 0f 4", prod, lat);
    end
  endtask

  task automatic test_back_to_back;
    int first, second;
    bit held;
    first = -1;
    second = -1;
    held = 1'b1;
    @(negedge clk);
    set_ops(4'd12, 4'd3);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_ops(4'd5, 4'd11);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (first < 0) first = k;
        else if (second < 0) begin
          second = k;
          start = 1'b0;
        end
      end
      if (first > 0 && second < 0 && product !== 8'h24) held = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (first !== 4) begin
      failures++;
      $display("FAIL b2b_first_done got %0d exp 4", first);
    end
    checks++;
    if (second - first !== 6) begin
      failures++;
      $display("FAIL b2b_spacing got %0d exp 6", second - first);
    end
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL b2b_hold got changed exp 24 held");
    end
    checks++;
    if (product !== 8'h37) begin
      failures++;
      $display("FAIL b2b_second_product got %h exp 37", product);
    end
  endtask

  task automatic test_random;
    int lat, bcyc;
    logic [7:0] prod;
    logic [3:0] a, b;
    logic [7:0] expv;
    for (int n = 0; n < 24; n++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      expv = 8'(int'(a) * int'(b));
      run_op(a, b, lat, bcyc, prod);
      checks++;
      if (prod !== expv || lat !== 4) begin
        failures++;
        $display("FAIL random_%0dx%0d got product=%h lat=%0d exp %h 4", a, b, prod, lat, expv);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    set_ops(4'd0, 4'd0);
    test_reset;
    test_basic;
    test_corners;
    test_ignore_inputs;
    test_abort;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_mult_accum.md
DIGIT_MULT_ACCUM -- requirements
Module: digit_mult_accum

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (2-bit digits, 8-bit product).
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request to begin one multiplication, sampled only in IDLE.
REQ-005 a_hi  input  2  operand A bits [3:2], from the upstream 4-bit split register.
REQ-006 a_lo  input  2  operand A bits [1:0].
REQ-007 b_hi  input  2  operand B bits [3:2].
REQ-008 b_lo  input  2  operand B bits [1:0].
REQ-009 busy  output  1  high while in CALC or DONE.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 product  output  8  registered result A*B, unsigned.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 IDLE->CALC SHALL occur on an edge where start=1. On that edge the block SHALL capture all four digits, clear the 8-bit accumulator and set the 2-bit step counter to 0.
REQ-014 In CALC, each edge SHALL add one partial product to the accumulator and increment the step counter.
- The partial product is a_i*b_j, a 4-bit unsigned value, shifted left by 2*(i+j).
- i = step[1], j = step[0]; digit index 0 = lo, 1 = hi.
REQ-015 Step order SHALL be lo*lo (shift 0), lo*hi (shift 2), hi*lo (shift 2), hi*hi (shift 4).
REQ-016 Accumulation SHALL be 8-bit unsigned; the maximum sum is 225, so no overflow or truncation occurs.
REQ-017 On the CALC edge where step=3, the FSM SHALL go to DONE. On that same edge, product SHALL load the final sum (accumulator plus the last partial product).
REQ-018 done SHALL be 1 only in DONE. DONE->IDLE SHALL occur unconditionally on the next edge, so done is exactly one cycle wide.
REQ-019 Latency: with start sampled at edge E0, done SHALL be high between E4 and E5, and product SHALL be valid from E4.
REQ-020 product SHALL hold its value until the next completion or a reset; it SHALL NOT change during CALC.
REQ-021 start SHALL be ignored in CALC and DONE; no restart and no operand recapture occur.
REQ-022 Changes on the digit inputs after the capture edge SHALL NOT affect the result in progress.
REQ-023 A start asserted in the IDLE cycle immediately after DONE SHALL be accepted. Back-to-back throughput SHALL be one result per 6 cycles.
REQ-024 busy SHALL be combinationally decoded from state: 1 in CALC and DONE, 0 in IDLE.

Reset
REQ-025 While rst=1, the block SHALL immediately force: state=IDLE, step=0, accumulator=0, product=0, done=0, busy=0.
REQ-026 A reset asserted mid-CALC or in DONE SHALL abort the operation; no done pulse is produced for the aborted operation.
REQ-027 After rst deasserts, the first edge with start=1 SHALL begin a normal operation.

Verification
REQ-028 Scenario: A=10 (a_hi=2'b10, a_lo=2'b10), B=10, start pulse. Required: done exactly 4 edges after start capture, product=8'h64, busy high for 5 cycles.
REQ-029 Scenario: A=15, B=15. Required: product=8'hE1 (225). Also check A=0, B=13 -> product=8'h00, with done still asserted.
REQ-030 Scenario: A=6, B=9 captured; digits change to A=15, B=15 and start is pulsed again during CALC. Required: product=8'h36 (54), and exactly one done pulse.
REQ-031 Scenario: rst asserted for 1 cycle during step 2 of A=7, B=7. Required: all outputs 0 immediately and no done. A subsequent A=3, B=5 run gives product=8'h0F.
REQ-032 Scenario: back-to-back runs A=12, B=3, then start held high through DONE with A=5, B=11. Required: product=8'h24, then product=8'h37. The second done follows the first by 6 cycles, and product holds 8'h24 until the second completion.
